wb_stream_writer: RTL and testbench
===================================

# wb_stream_writer

Wishbone-to-stream DMA engine: fetches a buffer of 32-bit words from system memory (HyperRAM or SRAM) over a Wishbone burst master port and presents them on a valid/ready stream output. It is the memory-to-stream counterpart of the frame-capture stream reader and sits as an additional master/slave pair on the generated Wishbone interconnect. Software programs the buffer address and length through a small Wishbone slave register file, starts the transfer, and receives an interrupt when the last word has left the stream port.

## Interface
- WB_AW, 32, master address width
- WB_DW, 32, data width (only 32 supported)
- FIFO_AW, 7, FIFO depth = 2**FIFO_AW words
- MAX_BURST_LEN, 16, max beats per Wishbone burst; must be ≤ 2**FIFO_AW
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wbm_adr_o  out  WB_AW  master byte address, word aligned
- wbm_dat_o  out  32  tied 0
- wbm_sel_o  out  4  4'hF during cycles, else 0
- wbm_we_o  out  1  tied 0 (read-only master)
- wbm_cyc_o / wbm_stb_o  out  1  bus cycle / strobe
- wbm_cti_o  out  3  3'b010 incrementing, 3'b111 last beat
- wbm_bte_o  out  2  2'b00 linear
- wbm_dat_i  in  32  read data
- wbm_ack_i / wbm_err_i  in  1  beat acknowledge / bus error
- m_data_o  out  32  stream data
- m_valid_o / m_ready_i  out/in  1  stream handshake
- m_last_o  out  1  high with the final word of the buffer
- irq_o  out  1  level interrupt = irq_pend & irq_en
- wbs_adr_i  in  5  slave register address (byte)
- wbs_dat_i / wbs_dat_o  in/out  32  slave write/read data
- wbs_sel_i  in  4  ignored (full-word access)
- wbs_we_i, wbs_cyc_i, wbs_stb_i  in  1  slave controls
- wbs_cti_i / wbs_bte_i  in  3/2  ignored
- wbs_ack_o  out  1  slave acknowledge

## Operation
- Registers (wbs_adr_i[4:2]): 0 CTRL/STATUS — write bit0=1 start (ignored while busy), bit1=1 clear irq_pend; read {29'b0, err, irq_pend, busy}. 1 START_ADR (bits[1:0] read 0). 2 BUF_SIZE in words. 3 IRQ_EN bit0. Other addresses read 0, writes dropped.
- Start latches START_ADR/BUF_SIZE into working address/remaining counters; later register writes do not affect the running transfer. Start also clears err.
- FSM: IDLE → (start, size≠0) WAIT; (start, size=0) → DONE with no bus cycle.
- WAIT: when FIFO free slots ≥ burst = min(MAX_BURST_LEN, remaining fetch count), go BURST.
- BURST: cyc/stb high; each ack writes wbm_dat_i to FIFO, adr += 4, remaining−1; cti=3'b111 on final beat; after final ack drop cyc/stb next edge, go WAIT if fetch remaining≠0 else DRAIN.
- Bursts never cross nothing special: address wraps mod 2**WB_AW.
- wbm_err_i during BURST: drop cyc, set err, flush FIFO, go DONE.
- DRAIN: wait until the word marked last is accepted on stream (valid&ready), go DONE.
- DONE: set irq_pend, clear busy, go IDLE (one cycle).
- busy = state≠IDLE.
- m_last_o asserted with word BUF_SIZE−1 only; never on size 0 or error.
- Stream: show-ahead sync FIFO; m_data_o/m_valid_o/m_last_o stable while valid & !ready.

## Timing
- Reset: all wbm_* outputs 0, m_valid_o=0, m_last_o=0, irq_o=0, wbs_ack_o=0, registers 0, FIFO empty, state IDLE. Reset mid-burst drops cyc/stb at the same edge, discards FIFO.
- Slave: wbs_ack_o asserted one cycle after cyc&stb, held one cycle; deasserted in the following cycle even if cyc&stb still high (no back-to-back acks). Writes take effect on the ack edge; wbs_dat_o valid with ack.
- Start write → wbm_cyc_o high 2 cycles later (WAIT evaluation 1 cycle).
- FIFO write on ack edge → m_valid_o high next cycle (1-cycle latency).
- Simultaneous FIFO push and pop allowed; occupancy unchanged.
- FIFO never overflows: free-slot check counts the full burst before cyc rises.
- irq_o rises the cycle after the last stream handshake (DONE edge); clear via CTRL bit1 falls it on the ack edge; a clear coinciding with DONE leaves irq_pend set.

## Test plan
- Reset then read regs 0x00–0x0C → all 0; all outputs 0.
- START_ADR=0x1000, BUF_SIZE=5, MAX_BURST_LEN=16, ready=1, IRQ_EN=1 → single burst adr 0x1000..0x1010, cti 010×4 then 111; stream yields 5 words in order, m_last_o on 5th; irq_o=1, status=3'b010.
- BUF_SIZE=40, FIFO_AW=4, m_ready_i low for 100 cycles → bursts 16,16,8; second burst not issued until ≥16 free slots; no data lost or duplicated.
- Random ready toggling + random ack wait states, BUF_SIZE=1000 → output matches memory model, m_data_o held while !ready.
- BUF_SIZE=0 start → no wbm_cyc_o, irq_pend set 2 cycles after ack; wbm_err_i on beat 3 → cyc drops, err=1, no m_last_o.
- Rst asserted mid-burst → cyc/stb/valid 0 next edge; subsequent start runs cleanly.

Source files
------------

// File: rtl/wb_stream_writer.sv
// wb_stream_writer: Wishbone burst-read DMA that streams a memory buffer out over valid/ready.
module wb_stream_writer #(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32,
  parameter int FIFO_AW = 7,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WB_AW-1:0] wbm_adr_o,
  output logic [WB_DW-1:0] wbm_dat_o,
  output logic [3:0]       wbm_sel_o,
  output logic             wbm_we_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic [2:0]       wbm_cti_o,
  output logic [1:0]       wbm_bte_o,
  input  logic [WB_DW-1:0] wbm_dat_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i,
  output logic [WB_DW-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             m_last_o,
  output logic             irq_o,
  input  logic [4:0]       wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic [31:0]      wbs_dat_o,
  input  logic [3:0]       wbs_sel_i,
  input  logic             wbs_we_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic [2:0]       wbs_cti_i,
  input  logic [1:0]       wbs_bte_i,
  output logic             wbs_ack_o
);
  localparam int CW = FIFO_AW + 1;
  localparam int DEPTH = 2 ** FIFO_AW;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_BURST, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_next;
  logic r_ack, r_irq_en, r_irq_pend, r_err;
  logic [31:0] r_rdat, r_size, r_fetch_rem, w_rd;
  logic [WB_AW-1:0] r_start_adr, r_adr;
  logic [CW-1:0] r_beats, r_cnt, w_burst, w_free;
  logic [FIFO_AW-1:0] r_wp, r_rp;
  logic [WB_DW:0] r_mem [DEPTH];
  logic w_req, w_wr, w_ctrl_wr, w_start, w_bus, w_push, w_pop, w_valid, w_err, w_last_beat, w_busy;
  logic [2:0] w_ra;
  logic w_unused;
  assign w_unused = &{1'b0, wbs_adr_i[1:0], wbs_sel_i, wbs_cti_i, wbs_bte_i};
  assign w_req = wbs_cyc_i & wbs_stb_i & !r_ack;
  assign w_ra = wbs_adr_i[4:2];
  assign w_wr = w_req & wbs_we_i;
  assign w_ctrl_wr = w_wr & (w_ra == 3'd0);
  assign w_busy = r_state != S_IDLE;
  assign w_start = w_ctrl_wr & wbs_dat_i[0] & !w_busy;
  assign w_bus = r_state == S_BURST;
  assign w_err = w_bus & wbm_err_i;
  assign w_push = w_bus & wbm_ack_i & !wbm_err_i;
  assign w_last_beat = r_beats == CW'(1);
  assign w_valid = r_cnt != '0;
  assign w_pop = w_valid & m_ready_i;
  assign w_burst = (r_fetch_rem < 32'(MAX_BURST_LEN)) ? r_fetch_rem[CW-1:0] : CW'(MAX_BURST_LEN);
  assign w_free = CW'(DEPTH) - r_cnt;
  assign wbm_dat_o = '0;
  assign wbm_we_o = 1'b0;
  assign wbm_bte_o = 2'b00;
  assign m_valid_o = w_valid;
  assign m_data_o = w_valid ? r_mem[r_rp][WB_DW-1:0] : '0;
  assign m_last_o = w_valid & r_mem[r_rp][WB_DW];
  assign irq_o = r_irq_pend & r_irq_en;
  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_rdat;
  always_ff @(posedge clk)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = (r_size == '0) ? S_DONE : S_WAIT;
      S_WAIT:  if (w_free >= w_burst) w_next = S_BURST;
      S_BURST: if (w_err) w_next = S_DONE;
               else if (w_push & w_last_beat) w_next = (r_fetch_rem == 32'd1) ? S_DRAIN : S_WAIT;
      S_DRAIN: if (w_pop & m_last_o) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    wbm_cyc_o = w_bus;
    wbm_stb_o = w_bus;
    wbm_sel_o = w_bus ? 4'hF : 4'h0;
    wbm_adr_o = w_bus ? r_adr : '0;
    wbm_cti_o = !w_bus ? 3'b000 : w_last_beat ? 3'b111 : 3'b010;
  end
  always_comb
    w_rd = (w_ra == 3'd0) ? {29'b0, r_err, r_irq_pend, w_busy} :
           (w_ra == 3'd1) ? 32'(r_start_adr) :
           (w_ra == 3'd2) ? r_size :
           (w_ra == 3'd3) ? {31'b0, r_irq_en} : 32'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack <= 1'b0;
      r_rdat <= '0;
      r_start_adr <= '0;
      r_size <= '0;
      r_irq_en <= 1'b0;
      r_irq_pend <= 1'b0;
      r_err <= 1'b0;
      r_adr <= '0;
      r_fetch_rem <= '0;
      r_beats <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_ack <= w_req;
      if (w_req) r_rdat <= w_rd;
      if (w_wr & (w_ra == 3'd1)) r_start_adr <= {wbs_dat_i[WB_AW-1:2], 2'b00};
      if (w_wr & (w_ra == 3'd2)) r_size <= wbs_dat_i;
      if (w_wr & (w_ra == 3'd3)) r_irq_en <= wbs_dat_i[0];
      // a DONE cycle wins over a simultaneous software clear
      if (r_state == S_DONE) r_irq_pend <= 1'b1;
      else if (w_ctrl_wr & wbs_dat_i[1]) r_irq_pend <= 1'b0;
      if (w_start) begin
        r_adr <= r_start_adr;
        r_fetch_rem <= r_size;
        r_err <= 1'b0;
      end
      if (w_err) r_err <= 1'b1;
      if ((r_state == S_WAIT) & (w_next == S_BURST)) r_beats <= w_burst;
      if (w_push) begin
        r_adr <= r_adr + WB_AW'(4);
        r_fetch_rem <= r_fetch_rem - 32'd1;
        r_beats <= r_beats - CW'(1);
      end
      if (w_err) begin
        r_wp <= '0;
        r_rp <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push) r_wp <= r_wp + FIFO_AW'(1);
        if (w_pop) r_rp <= r_rp + FIFO_AW'(1);
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end
  // the word fetched while one beat of the buffer remains carries the last flag
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= {r_fetch_rem == 32'd1, wbm_dat_i};
endmodule

// File: tb/tb_wb_stream_writer.sv
// tb_wb_stream_writer: directed checks of the Wishbone-to-stream DMA with a memory/stream model.
module tb_wb_stream_writer;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i, m_data_o, wbs_dat_i, wbs_dat_o;
  logic [3:0] wbm_sel_o, wbs_sel_i;
  logic [2:0] wbm_cti_o, wbs_cti_i;
  logic [1:0] wbm_bte_o, wbs_bte_i;
  logic [4:0] wbs_adr_i;
  logic wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i, m_valid_o, m_ready_i, m_last_o, irq_o;
  logic wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_ack_o;
  wb_stream_writer #(.WB_AW(32), .WB_DW(32), .FIFO_AW(4), .MAX_BURST_LEN(16)) dut (
    .clk(clk), .rst(rst), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o),
    .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_last_o(m_last_o),
    .irq_o(irq_o), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
    .wbs_sel_i(wbs_sel_i), .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i), .wbs_ack_o(wbs_ack_o)
  );
  int n_checks = 0, n_errors = 0;
  int wait_pct = 0, rdy_mode = 0, err_at = -1;
  int b_idx, b_size, s_idx, s_size, occ, occ_max, last_cnt, cur_len;
  int lens[$];
  logic [31:0] b_base, s_base, prev_data, q;
  logic prev_stall = 1'b0, prev_last = 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction
  task automatic arm(input logic [31:0] base, input int size);
    b_base = base; b_size = size; b_idx = 0;
    s_base = base; s_size = size; s_idx = 0;
    occ = 0; occ_max = 0; last_cnt = 0; cur_len = 0;
    lens.delete();
  endtask
  task automatic wb_xfer(input logic we, input logic [4:0] a, input logic [31:0] d, output logic [31:0] r);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_adr_i = a; wbs_dat_i = d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wbs_ack_o) break;
    end
    chk("wbs_ack", wbs_ack_o, 1);
    r = wbs_dat_o;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, d, dummy);
  endtask
  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(1'b0, a, 32'h0, r);
    chk(tag, r, exp);
  endtask
  task automatic wait_irq(input int bound);
    for (int i = 0; i < bound && !irq_o; i++) @(negedge clk);
    chk("irq_timeout", irq_o, 1);
  endtask
  // memory slave, stream sink and scoreboard, all evaluated at the falling edge
  initial forever begin
    @(negedge clk);
    if (rst) begin
      wbm_ack_i = 0; wbm_err_i = 0; prev_stall = 0;
    end else begin
      m_ready_i = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
      wbm_err_i = wbm_cyc_o && wbm_stb_o && (b_idx == err_at);
      wbm_ack_i = wbm_cyc_o && wbm_stb_o && !wbm_err_i && ($urandom_range(0, 99) >= wait_pct);
      wbm_dat_i = mem_word(wbm_adr_o);
      if (prev_stall) begin
        chk("hold_valid", m_valid_o, 1);
        chk("hold_data", m_data_o, prev_data);
        chk("hold_last", m_last_o, prev_last);
      end
      if (wbm_ack_i) begin
        chk("beat_adr", wbm_adr_o, b_base + 32'(4 * b_idx));
        chk("beat_cti", wbm_cti_o, (b_idx % 16 == 15 || b_idx == b_size - 1) ? 32'd7 : 32'd2);
        chk("beat_sel", wbm_sel_o, 4'hF);
        cur_len++;
        if (wbm_cti_o == 3'b111) begin lens.push_back(cur_len); cur_len = 0; end
        b_idx++; occ++;
      end
      if (m_valid_o && m_ready_i) begin
        chk("s_data", m_data_o, mem_word(s_base + 32'(4 * s_idx)));
        chk("s_last", m_last_o, s_idx == s_size - 1);
        last_cnt += int'(m_last_o); s_idx++; occ--;
      end
      if (occ > occ_max) occ_max = occ;
      prev_stall = m_valid_o && !m_ready_i;
      prev_data = m_data_o;
      prev_last = m_last_o;
    end
  end
  initial begin
    wbs_adr_i = 0; wbs_dat_i = 0; wbs_sel_i = 4'hF; wbs_we_i = 0; wbs_cyc_i = 0; wbs_stb_i = 0;
    wbs_cti_i = 0; wbs_bte_i = 0; wbm_ack_i = 0; wbm_err_i = 0; wbm_dat_i = 0; m_ready_i = 0;
    arm(32'h0, 0);
    repeat (3) @(negedge clk);
    chk("rst_cyc", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 0);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_sel", wbm_sel_o, 0);
    chk("rst_stream", {m_valid_o, m_last_o, irq_o, wbs_ack_o}, 0);
    rst = 0;
    @(negedge clk);
    rd("reg0_rst", 5'h00, 0); rd("reg1_rst", 5'h04, 0); rd("reg2_rst", 5'h08, 0); rd("reg3_rst", 5'h0C, 0);
    // single 5-beat burst, start address low bits masked
    arm(32'h1000, 5); rdy_mode = 1;
    wr(5'h04, 32'h1003); rd("start_adr_mask", 5'h04, 32'h1000);
    wr(5'h08, 5); rd("buf_size", 5'h08, 5);
    wr(5'h0C, 1); rd("irq_en", 5'h0C, 1);
    wr(5'h10, 32'hFFFF); rd("reg_other", 5'h10, 0);
    wr(5'h00, 1);
    chk("cyc_wait", wbm_cyc_o, 0);
    @(negedge clk);
    chk("cyc_rise", wbm_cyc_o, 1);
    wait_irq(100);
    chk("t1_words", s_idx, 5); chk("t1_last", last_cnt, 1);
    chk("t1_bursts", lens.size(), 1); chk("t1_len", lens[0], 5);
    rd("t1_status", 5'h00, 32'h2);
    wr(5'h00, 2);
    chk("irq_clear", irq_o, 0);
    // stalled sink: FIFO of 16 fills, next burst waits for 16 free slots
    arm(32'h2000, 40); rdy_mode = 0;
    wr(5'h04, 32'h2000); wr(5'h08, 40); wr(5'h00, 1);
    repeat (100) @(negedge clk);
    chk("t2_beats_stalled", b_idx, 16); chk("t2_cyc_idle", wbm_cyc_o, 0);
    chk("t2_valid", m_valid_o, 1); chk("t2_status_busy", irq_o, 0);
    rdy_mode = 1;
    wait_irq(400);
    chk("t2_words", s_idx, 40); chk("t2_last", last_cnt, 1); chk("t2_occ", occ_max, 16);
    chk("t2_bursts", lens.size(), 3);
    chk("t2_len0", lens[0], 16); chk("t2_len1", lens[1], 16); chk("t2_len2", lens[2], 8);
    wr(5'h00, 2);
    // random backpressure and wait states, address wraps past zero
    arm(32'hFFFF_FF00, 1000); rdy_mode = 2; wait_pct = 30;
    wr(5'h04, 32'hFFFF_FF00); wr(5'h08, 1000); wr(5'h00, 1);
    wait_irq(20000);
    chk("t3_words", s_idx, 1000); chk("t3_beats", b_idx, 1000); chk("t3_last", last_cnt, 1);
    chk("t3_bursts", lens.size(), 63); chk("t3_occ_ok", occ_max <= 16, 1);
    rdy_mode = 1; wait_pct = 0;
    wr(5'h00, 2);
    // zero-length buffer
    arm(32'h0, 0);
    wr(5'h08, 0); wr(5'h00, 1);
    chk("t4_irq_pre", irq_o, 0);
    @(negedge clk);
    chk("t4_irq", irq_o, 1);
    repeat (3) @(negedge clk);
    chk("t4_no_beats", b_idx, 0);
    rd("t4_status", 5'h00, 32'h2);
    wr(5'h00, 2);
    // bus error on third beat
    arm(32'h3000, 10); err_at = 2;
    wr(5'h04, 32'h3000); wr(5'h08, 10); wr(5'h00, 1);
    wait_irq(100);
    err_at = -1;
    chk("t5_beats", b_idx, 2); chk("t5_cyc", wbm_cyc_o, 0);
    chk("t5_valid", m_valid_o, 0); chk("t5_no_last", last_cnt, 0);
    rd("t5_status", 5'h00, 32'h6);
    wr(5'h00, 2);
    arm(32'h3000, 3);
    wr(5'h08, 3); wr(5'h00, 1);
    wait_irq(100);
    chk("t5_rerun", s_idx, 3);
    rd("t5_err_cleared", 5'h00, 32'h2);
    wr(5'h00, 2);
    // reset in the middle of a burst
    arm(32'h4000, 40); rdy_mode = 0;
    wr(5'h04, 32'h4000); wr(5'h08, 40); wr(5'h00, 1);
    for (int i = 0; i < 10 && !wbm_cyc_o; i++) @(negedge clk);
    chk("t6_cyc_up", wbm_cyc_o, 1);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("t6_rst_bus", {wbm_cyc_o, wbm_stb_o}, 0);
    chk("t6_rst_stream", {m_valid_o, irq_o}, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    rd("t6_size_cleared", 5'h08, 0);
    arm(32'h5000, 3); rdy_mode = 1;
    wr(5'h04, 32'h5000); wr(5'h08, 3); wr(5'h0C, 1); wr(5'h00, 1);
    wait_irq(100);
    chk("t6_words", s_idx, 3); chk("t6_last", last_cnt, 1); chk("t6_len", lens[0], 3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
